rr_arbiter4: RTL and testbench
==============================

// Module: rr_arbiter4
// PURPOSE
//   Four-requester round-robin arbiter that shares one downstream resource.
//   Selects a winner index, holds the grant while the winner keeps requesting,
//   and outputs the grant as a registered index plus a one-hot vector.
//   The one-hot vector is the 2:4 decode of the index, gated by enable.
//   Sits between four request sources and the shared resource's select logic.
// PARAMETERS
//   MAX_HOLD  8  max consecutive grant cycles per winner; legal 1..255; used only with RR_HOLD_LIMIT_EN
//   HOLD_W    8  hold-counter width; must satisfy 2**HOLD_W > MAX_HOLD
// PORTS
//   clk        in   1  single clock; all state updates on rising edge
//   rst        in   1  synchronous, active-high reset
//   en         in   1  global enable; 0 blocks new grants and ends the current one
//   req        in   4  request per requester, level-sensitive
//   gnt        out  4  one-hot grant; equals decode(gnt_idx) when gnt_valid=1, else 4'b0000
//   gnt_idx    out  2  index of the current winner; 2'b00 when gnt_valid=0
//   gnt_valid  out  1  a grant is active
// BEHAVIOUR
//   Reset (clk edge with rst=1):
//     gnt=0000, gnt_idx=00, gnt_valid=0, ptr=00, hold_cnt=0, state=IDLE.
//     rst dominates every other input, including mid-grant.
//   State IDLE:
//     - Condition: en=1 and |req.
//     - Search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4). First set req bit wins.
//     - Next edge: state=GRANT, gnt_idx=winner, gnt_valid=1, hold_cnt=1.
//     - Latency: 1 clock from a sampled req to a visible gnt.
//     - No grant is issued in the same cycle as a release, so every handover has
//       at least one idle cycle (gnt=0000).
//   State GRANT: release occurs at the next edge when any of these holds:
//     (a) req[gnt_idx]=0
//     (b) en=0
//     (c) the hold limit is reached (RR_HOLD_LIMIT_EN only)
//   On release:
//     - state=IDLE, gnt_valid=0, gnt=0000, gnt_idx=00
//     - ptr=gnt_idx+1 (2-bit wrap: 11 -> 00)
//   Otherwise the grant holds unchanged and hold_cnt increments, saturating at 2**HOLD_W-1.
//   Requests from non-winners are ignored during GRANT. They are never latched.
//   Simultaneous release causes (e.g. req drop together with hold expiry) produce one
//   identical release; ptr advances once.
//   en=0 in IDLE: no grant is issued and ptr is unchanged.
//   gnt is always the combinational decode of the registered gnt_idx/gnt_valid:
//     - at most one bit set
//     - glitch-free with respect to req
// CONFIGURATION
//   RR_HOLD_LIMIT_EN defined:
//     - Release condition (c) is active: when hold_cnt==MAX_HOLD and req is still high,
//       release at the next edge.
//     - Every grant lasts at most MAX_HOLD cycles.
//   RR_HOLD_LIMIT_EN undefined:
//     - There is no hold limit; a winner keeps the grant while req[gnt_idx]=1 and en=1.
//     - hold_cnt may be removed. MAX_HOLD and HOLD_W are ignored.
// TESTING
//   1 Reset: rst=1 for 2 cycles with en=1, req=1111 -> gnt=0000, gnt_idx=00,
//     gnt_valid=0 throughout. After rst=0: gnt=0001 one cycle later.
//   2 Single: en=1, req=0100 for 3 cycles then 0000 -> gnt=0100, idx=10 from
//     cycle+1 for 3 cycles; gnt=0000 on the edge after the drop. Next winner
//     search starts at 11.
//   3 Rotation: req=1111; each winner drops its req for 1 cycle after 2 grant
//     cycles -> grant order 0001,0010,0100,1000,0001, one idle cycle between each.
//   4 Hold limit (RR_HOLD_LIMIT_EN, MAX_HOLD=4): req=0010 held high ->
//     gnt=0010 for 4 cycles, 0000 for 1, then 0010 again.
//     Without the macro: gnt=0010 continuously.
//   5 Enable: en=0, req=1111 for 5 cycles -> gnt=0000.
//     en 1->0 while gnt=0100 -> gnt=0000 next edge; next grant with en=1,
//     req=1111 is 1000.
//   6 Reset mid-grant: rst pulsed while gnt=1000 -> gnt=0000 next edge, ptr=00.
//     Then req=1001, en=1 -> gnt=0001.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered grant index and a one-hot decode.
// Optional per-grant hold limit enabled by defining RR_HOLD_LIMIT_EN.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

`ifdef RR_HOLD_LIMIT_EN
  localparam logic HOLD_LIMIT_ON = 1'b1;
`else
  localparam logic HOLD_LIMIT_ON = 1'b0;
`endif
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic              found_c;
  logic [1:0]        winner_c;
  logic              limit_c;
  logic              release_c;

  // Scan from the farthest offset down so the requester closest to ptr wins.
  always_comb begin
    found_c  = 1'b0;
    winner_c = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) begin
        found_c  = 1'b1;
        winner_c = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    limit_c   = HOLD_LIMIT_ON && (hold_cnt_q == HOLD_LIM);
    release_c = !req[idx_q] || !en || limit_c;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en && found_c) begin
          state_d    = ST_GRANT;
          idx_d      = winner_c;
          hold_cnt_d = HOLD_W'(1);
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          state_d    = ST_IDLE;
          idx_d      = 2'b00;
          ptr_d      = idx_q + 2'd1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 2'b00;
      idx_q      <= 2'b00;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Outputs decode registered state only, so req activity cannot glitch them.
  always_comb begin
    gnt_valid = (state_q == ST_GRANT);
    gnt_idx   = idx_q;
    gnt       = 4'b0000;
    if (gnt_valid) gnt[idx_q] = 1'b1;
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: owner is -1 when no grant is active.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit limit_on();
`ifdef RR_HOLD_LIMIT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected {gnt_valid, gnt_idx, gnt} from the model.
  function automatic logic [6:0] model_out();
    logic [3:0] g;
    if (m_owner < 0) return 7'b0;
    g = 4'b0001 << m_owner;
    return {1'b1, 2'(m_owner), g};
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] g;
    g = 4'b0001 << i;
    return g;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [3:0] q);
    if (r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      if (e && q != 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          if (q[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            m_hold  = 1;
            break;
          end
        end
      end
    end else begin
      if (!q[m_owner] || !e || (limit_on() && m_hold >= MAX_HOLD)) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_hold  = 0;
      end else begin
        m_hold++;
      end
    end
  endtask

  // Driver: apply inputs for one cycle, advance the model at the edge, settle.
  task automatic drive(input logic r, input logic e, input logic [3:0] q);
    rst = r; en = e; req = q;
    @(posedge clk);
    model_step(r, e, q);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 4'b1111);
      n_tests++;
      if ({gnt_valid, gnt_idx, gnt} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b_%b_%b expected 0_00_0000", i, gnt_valid, gnt_idx, gnt);
      end
    end
    drive(1'b0, 1'b1, 4'b1111);
    n_tests++;
    if ({gnt_valid, gnt_idx, gnt} !== 7'b1_00_0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b_%b_%b expected 1_00_0001", gnt_valid, gnt_idx, gnt);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'b0100);
      n_tests++;
      if ({gnt_valid, gnt_idx, gnt} !== 7'b1_10_0100) begin
        n_fail++;
        $display("FAIL single_hold[%0d]: got %b_%b_%b expected 1_10_0100", i, gnt_valid, gnt_idx, gnt);
      end
    end
    drive(1'b0, 1'b1, 4'b0000);
    n_tests++;
    if ({gnt_valid, gnt_idx, gnt} !== 7'b0) begin
      n_fail++;
      $display("FAIL single_release: got %b_%b_%b expected 0_00_0000", gnt_valid, gnt_idx, gnt);
    end
    drive(1'b0, 1'b1, 4'b1111);
    n_tests++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_next_ptr: got %b expected 1000", gnt);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    drive(1'b1, 1'b1, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 2; c++) begin
        drive(1'b0, 1'b1, 4'b1111);
        n_tests++;
        if (gnt !== order[k]) begin
          n_fail++;
          $display("FAIL rotation[%0d.%0d]: got %b expected %b", k, c, gnt, order[k]);
        end
      end
      drive(1'b0, 1'b1, 4'b1111 & ~order[k]);
      n_tests++;
      if (gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL rotation_gap[%0d]: got %b expected 0000", k, gnt);
      end
    end
  endtask

  task automatic test_hold_limit();
    logic [3:0] exp_g;
    drive(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 4'b0010);
      exp_g = (limit_on() && (i % (MAX_HOLD + 1)) == MAX_HOLD) ? 4'b0000 : 4'b0010;
      n_tests++;
      if (gnt !== exp_g || {gnt_valid, gnt_idx, gnt} !== model_out()) begin
        n_fail++;
        $display("FAIL hold_limit[%0d]: got %b expected %b", i, gnt, exp_g);
      end
    end
  endtask

  task automatic test_enable();
    drive(1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 4'b1111);
      n_tests++;
      if (gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL enable_off[%0d]: got %b expected 0000", i, gnt);
      end
    end
    drive(1'b0, 1'b1, 4'b0100);
    drive(1'b0, 1'b1, 4'b0100);
    n_tests++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL enable_setup: got %b expected 0100", gnt);
    end
    drive(1'b0, 1'b0, 4'b1111);
    n_tests++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL enable_drop: got %b expected 0000", gnt);
    end
    drive(1'b0, 1'b1, 4'b1111);
    n_tests++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL enable_next: got %b expected 1000", gnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    // Arrives with gnt=1000 held from the enable scenario.
    drive(1'b1, 1'b1, 4'b1111);
    n_tests++;
    if ({gnt_valid, gnt_idx, gnt} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %b_%b_%b expected 0_00_0000", gnt_valid, gnt_idx, gnt);
    end
    drive(1'b0, 1'b1, 4'b1001);
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid_next: got %b expected 0001", gnt);
    end
    // Reset while ptr is non-zero must restart the search at requester 0.
    drive(1'b0, 1'b1, 4'b0000);
    drive(1'b0, 1'b1, 4'b0100);
    drive(1'b1, 1'b1, 4'b0100);
    drive(1'b0, 1'b1, 4'b1111);
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_ptr_clear: got %b expected 0001", gnt);
    end
  endtask

  task automatic test_random();
    logic       r, e;
    logic [3:0] q;
    logic [6:0] exp_o;
    int         errs = 0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 40) == 0);
      e = ($urandom_range(0, 5) != 0);
      // Bias towards the current owner keeping its request so grants last a while.
      q = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) q = q | onehot(m_owner);
      drive(r, e, q);
      exp_o = model_out();
      n_tests++;
      if ({gnt_valid, gnt_idx, gnt} !== exp_o) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: got %b_%b_%b expected %b_%b_%b (rst=%b en=%b req=%b)",
                   i, gnt_valid, gnt_idx, gnt, exp_o[6], exp_o[5:4], exp_o[3:0], r, e, q);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_hold_limit();
    test_enable();
    test_reset_mid_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
